// File: rtl/fft_r4_pkg.sv
// Shared definitions for the 16-point radix-4 FFT sequencer:
// state encoding, transform geometry constants, digit reversal and
// per-stage butterfly address / twiddle generation.
package fft_r4_pkg;

    localparam int N_PTS        = 16;
    localparam int RADIX        = 4;
    localparam int N_STAGES     = 2;
    localparam int BF_PER_STAGE = 4;
    localparam int ADDR_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_S0_ISSUE = 3'd2,
        ST_S0_DRAIN = 3'd3,
        ST_S1_ISSUE = 3'd4,
        ST_S1_DRAIN = 3'd5,
        ST_UNLOAD   = 3'd6
    } state_t;

    // Base-4 digit reversal of a 4-bit index: {n[1:0], n[3:2]}.
    function automatic logic [3:0] digit_rev(input logic [3:0] n);
        return {n[1:0], n[3:2]};
    endfunction

    // Stage 0 butterfly b reads legs b, b+4, b+8, b+12 (leg k = {k, b}).
    function automatic logic [15:0] s0_rd_addr(input logic [1:0] b);
        return {2'd3, b, 2'd2, b, 2'd1, b, 2'd0, b};
    endfunction

    // Stage 1 butterfly b reads legs 4b, 4b+1, 4b+2, 4b+3 (leg k = {b, k}).
    function automatic logic [15:0] s1_rd_addr(input logic [1:0] b);
        return {b, 2'd3, b, 2'd2, b, 2'd1, b, 2'd0};
    endfunction

    // Stage 0 twiddle exponents for legs 1..3: (k*b) mod 16, negated mod 16 for the inverse.
    function automatic logic [11:0] s0_tw_exp(input logic [1:0] b, input logic inv);
        logic [11:0] tw;
        logic [3:0]  e;
        tw = '0;
        for (int k = 1; k < RADIX; k++) begin
            e = 4'(k) * {2'b00, b};
            if (inv) begin
                e = 4'd0 - e;
            end
            tw[4*(k-1) +: 4] = e;
        end
        return tw;
    endfunction

endpackage

// File: rtl/fft_r4_wb_delay.sv
// Write-back delay line: carries the butterfly issue valid and its four
// read addresses for DEPTH cycles so they come back out as the in-place
// write enable and write addresses. clear empties every stage.
module fft_r4_wb_delay
    import fft_r4_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     shift_valid,
    input  logic [RADIX*ADDR_W-1:0]  shift_addr,
    output logic                     tap_valid,
    output logic [RADIX*ADDR_W-1:0]  tap_addr
);

    logic [DEPTH-1:0]        vld;
    logic [RADIX*ADDR_W-1:0] addr [DEPTH];

    // Shift valid/address one stage per cycle; clear or reset empties the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) addr[i] <= '0;
        end else if (clear) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) addr[i] <= '0;
        end else begin
            vld[0]  <= shift_valid;
            addr[0] <= shift_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]  <= vld[i-1];
                addr[i] <= addr[i-1];
            end
        end
    end

    assign tap_valid = vld[DEPTH-1];
    assign tap_addr  = addr[DEPTH-1];

endmodule

// File: rtl/fft16_r4_sequencer.sv
// Address-generating controller for a 16-point, 2-stage radix-4 in-place FFT.
// Loads 16 samples, issues 4 butterflies per stage, writes results back
// BF_LAT cycles after issue, then streams results out in natural order.
// Optional build macro FFT_R4_INVERSE_EN adds the inv port (inverse twiddles).
//
// Handshakes: a beat transfers in the cycle where valid and ready are both
// high at the rising edge. in_ready is high for the whole LOAD state and does
// not depend on in_valid; out_valid, once high, holds with out_rd_addr stable
// until out_ready accepts it.
module fft16_r4_sequencer
    import fft_r4_pkg::state_t, fft_r4_pkg::ST_IDLE, fft_r4_pkg::ST_LOAD,
           fft_r4_pkg::ST_S0_ISSUE, fft_r4_pkg::ST_S0_DRAIN, fft_r4_pkg::ST_S1_ISSUE,
           fft_r4_pkg::ST_S1_DRAIN, fft_r4_pkg::ST_UNLOAD, fft_r4_pkg::ADDR_W,
           fft_r4_pkg::BF_PER_STAGE, fft_r4_pkg::digit_rev, fft_r4_pkg::s0_rd_addr,
           fft_r4_pkg::s1_rd_addr, fft_r4_pkg::s0_tw_exp;
#(
    parameter int BF_LAT = 2,
    parameter int N_PTS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef FFT_R4_INVERSE_EN
    input  logic        inv,
`endif
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        ld_we,
    output logic [3:0]  ld_addr,
    output logic        mux_sel,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    output logic [11:0] tw_exp,
    output logic        bf_valid,
    output logic        stage,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_rd_addr,
    output logic        out_last,
    output state_t      dbg_state
);

    if (BF_LAT < 1 || BF_LAT > 8 || N_PTS != 16) begin : g_param_check
        $error("fft16_r4_sequencer: BF_LAT must be 1..8 and N_PTS must be 16");
    end

    localparam logic [ADDR_W-1:0] LAST_PT    = ADDR_W'(N_PTS - 1);
    localparam logic [ADDR_W-1:0] LAST_BF    = ADDR_W'(BF_PER_STAGE - 1);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(BF_LAT - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              last_accept;
    logic              inv_run;
    logic              wb_clear;

`ifdef FFT_R4_INVERSE_EN
    logic inv_q;

    // Capture the transform direction when a run is accepted; held until the next run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            inv_q <= inv;
        end
    end

    assign inv_run = inv_q;
`else
    assign inv_run = 1'b0;
`endif

    // State, shared counter and done pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= last_accept;
        end
    end

    // Next state and per-state outputs; cnt is the sample, butterfly, drain or output index
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_accept = 1'b0;
        in_ready    = 1'b0;
        ld_we       = 1'b0;
        ld_addr     = '0;
        mux_sel     = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        tw_exp      = '0;
        stage       = 1'b0;
        out_valid   = 1'b0;
        out_rd_addr = '0;
        out_last    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                ld_addr  = cnt;
                ld_we    = in_valid;
                if (in_valid) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_PT) begin
                        state_nxt = ST_S0_ISSUE;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_S0_ISSUE: begin
                mux_sel = 1'b1;
                rd_en   = 1'b1;
                rd_addr = s0_rd_addr(cnt[1:0]);
                tw_exp  = s0_tw_exp(cnt[1:0], inv_run);
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_BF) begin
                    state_nxt = ST_S0_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            ST_S0_DRAIN: begin
                mux_sel = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == DRAIN_LAST) begin
                    state_nxt = ST_S1_ISSUE;
                    cnt_nxt   = '0;
                end
            end
            ST_S1_ISSUE: begin
                mux_sel = 1'b1;
                stage   = 1'b1;
                rd_en   = 1'b1;
                rd_addr = s1_rd_addr(cnt[1:0]);
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_BF) begin
                    state_nxt = ST_S1_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            ST_S1_DRAIN: begin
                mux_sel = 1'b1;
                stage   = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == DRAIN_LAST) begin
                    state_nxt = ST_UNLOAD;
                    cnt_nxt   = '0;
                end
            end
            ST_UNLOAD: begin
                out_valid   = 1'b1;
                out_rd_addr = digit_rev(cnt);
                out_last    = (cnt == LAST_PT);
                if (out_ready) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_PT) begin
                        state_nxt   = ST_IDLE;
                        cnt_nxt     = '0;
                        last_accept = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign bf_valid  = rd_en;
    assign dbg_state = state;
    assign wb_clear  = (state == ST_IDLE);

    fft_r4_wb_delay #(
        .DEPTH (BF_LAT)
    ) u_wb_delay (
        .clk         (clk),
        .rst         (rst),
        .clear       (wb_clear),
        .shift_valid (rd_en),
        .shift_addr  (rd_addr),
        .tap_valid   (wr_en),
        .tap_addr    (wr_addr)
    );

endmodule

// File: tb/tb_fft16_r4_sequencer.sv
// Self-checking bench for fft16_r4_sequencer. A cycle-level reference model
// (phase + index counters, expected write-back queue) predicts every output
// from the sequencing rules; stimulus uses directed and $urandom patterns.
`timescale 1ns/1ps
module tb_fft16_r4_sequencer;

    localparam int BF = 2;
    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_COMP   = 2;
    localparam int P_UNLOAD = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, in_ready, ld_we, mux_sel, rd_en, bf_valid, stage, wr_en;
    logic        out_valid, out_last;
    logic [3:0]  ld_addr, out_rd_addr;
    logic [15:0] rd_addr, wr_addr;
    logic [11:0] tw_exp;
    fft_r4_pkg::state_t dbg_state;
`ifdef FFT_R4_INVERSE_EN
    logic        inv = 1'b0;
`endif

    always #5 clk = ~clk;

    fft16_r4_sequencer #(.BF_LAT(BF), .N_PTS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef FFT_R4_INVERSE_EN
        .inv         (inv),
`endif
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .mux_sel     (mux_sel),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .tw_exp      (tw_exp),
        .bf_valid    (bf_valid),
        .stage       (stage),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd_addr (out_rd_addr),
        .out_last    (out_last),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          m_phase = P_IDLE;
    int          m_cnt = 0;
    int          m_t = 0;
    int          m_n = 0;
    int          done_due = -1;
    logic        m_inv = 1'b0;
    int          due_q[$];
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference address/twiddle rules written as plain arithmetic
    function automatic logic [15:0] ref_rd(input int stg, input int b);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((stg == 0) ? (b + 4*k) : (4*b + k));
        return r;
    endfunction

    function automatic logic [11:0] ref_tw(input int stg, input int b, input logic iv);
        logic [11:0] r;
        r = '0;
        if (stg == 0) begin
            for (int k = 1; k < 4; k++)
                r[4*(k-1) +: 4] = 4'(iv ? ((16 - k*b) % 16) : ((k*b) % 16));
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_out(input int n);
        return 4'((n % 4) * 4 + n / 4);
    endfunction

    // ---------------- monitor + reference model ----------------
    always @(negedge clk) begin
        bit exp_rd;
        int stg;
        int b;
        cyc++;
        if (rst) begin
            check_eq("rst_busy", busy, 0);
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_rd_en", rd_en, 0);
            check_eq("rst_wr_en", wr_en, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_ld_addr", ld_addr, 0);
            m_phase = P_IDLE;
            m_cnt = 0;
            m_t = 0;
            m_n = 0;
            done_due = -1;
            due_q.delete();
            exp_q.delete();
        end else begin
            check_eq("busy", busy, m_phase != P_IDLE);
            check_eq("in_ready", in_ready, m_phase == P_LOAD);
            check_eq("ld_we", ld_we, (m_phase == P_LOAD) && in_valid);
            if (m_phase == P_LOAD) begin
                check_eq("mux_sel_load", mux_sel, 0);
                if (in_valid) check_eq("ld_addr", ld_addr, m_cnt);
            end
            exp_rd = 0;
            stg = 0;
            b = 0;
            if (m_phase == P_COMP) begin
                if (m_t < 4) begin
                    exp_rd = 1;
                    b = m_t;
                end else if (m_t >= 4 + BF && m_t < 8 + BF) begin
                    exp_rd = 1;
                    stg = 1;
                    b = m_t - 4 - BF;
                end
                check_eq("mux_sel_comp", mux_sel, 1);
                check_eq("stage", stage, m_t >= 4 + BF);
            end
            check_eq("rd_en", rd_en, exp_rd);
            check_eq("bf_valid", bf_valid, exp_rd);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                check_eq("wr_en", wr_en, 1);
                check_eq("wr_addr", wr_addr, exp_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end else begin
                check_eq("wr_en", wr_en, 0);
            end
            if (exp_rd) begin
                check_eq("rd_addr", rd_addr, ref_rd(stg, b));
                check_eq("tw_exp", tw_exp, ref_tw(stg, b, m_inv));
                if (stg == 0 && b == 1) check_eq("rd_addr_s0_b1", rd_addr, 16'hD951);
                due_q.push_back(cyc + BF);
                exp_q.push_back(ref_rd(stg, b));
            end
            check_eq("out_valid", out_valid, m_phase == P_UNLOAD);
            if (m_phase == P_UNLOAD) begin
                check_eq("out_rd_addr", out_rd_addr, ref_out(m_n));
                check_eq("out_last", out_last, m_n == 15);
            end
            check_eq("done", done, cyc == done_due);
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase = P_LOAD;
                    m_cnt = 0;
`ifdef FFT_R4_INVERSE_EN
                    m_inv = inv;
`endif
                end
                P_LOAD: if (in_valid) begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_phase = P_COMP;
                        m_t = 0;
                    end
                end
                P_COMP: begin
                    m_t++;
                    if (m_t == 8 + 2*BF) begin
                        m_phase = P_UNLOAD;
                        m_n = 0;
                    end
                end
                P_UNLOAD: if (out_ready) begin
                    if (m_n == 15) begin
                        m_phase = P_IDLE;
                        done_due = cyc + 1;
                    end else begin
                        m_n++;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // ---------------- driver ----------------
    // mode 0: free flow; 1: in_valid toggles; 2: out_ready stall at n=5;
    // 3: random valid/ready and stray starts; 4: start in S1 issue and unload;
    // 5: reset during stage-0 butterfly 2
    task automatic run(input int mode);
        int  k;
        bit  fin;
        int  stall;
        k = 0;
        fin = 0;
        stall = 0;
`ifdef FFT_R4_INVERSE_EN
        inv = 1'($urandom_range(0, 1));
`endif
        while (!fin && k < 600) begin
            @(posedge clk);
            #1;
            if (k > 0 && m_phase == P_IDLE) begin
                fin = 1;
            end else if (mode == 5 && m_phase == P_COMP && m_t == 2) begin
                rst = 1'b1;
                start = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                fin = 1;
            end else begin
                start = (k == 0);
                in_valid = 1'b1;
                out_ready = 1'b1;
                case (mode)
                    1: in_valid = (k % 2 == 1);
                    2: if (m_phase == P_UNLOAD && m_n == 5 && stall < 3) begin
                        out_ready = 1'b0;
                        stall++;
                    end
                    3: begin
                        in_valid = 1'($urandom_range(0, 1));
                        out_ready = ($urandom_range(0, 3) != 0);
                        if (k != 0 && m_phase != P_IDLE) start = ($urandom_range(0, 7) == 0);
                    end
                    4: if ((m_phase == P_COMP && m_t == 4 + BF) || (m_phase == P_UNLOAD && m_n == 3))
                        start = 1'b1;
                    default: ;
                endcase
            end
            k++;
        end
        check_eq("run_complete", fin, 1);
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (BF + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run(5);
        run(0);
        run(1);
        run(2);
        run(4);
        for (int i = 0; i < 4; i++) run(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fft16_r4_sequencer.md
Name: fft16_r4_sequencer

Overview:
Sequencer for the 16-point, 2-stage radix-4 in-place FFT datapath: register bank, radix-4 butterfly and twiddle ROM. It does four things:
- Streams 16 samples into the bank.
- Issues 4 butterflies per stage with read, twiddle and write addresses.
- Tracks butterfly pipeline latency for write-back.
- Streams results out in natural order with backpressure.

Replaces the fixed-timing stage FSM with an address-generating, handshaked controller.

Parameters:
BF_LAT, 2, butterfly pipeline latency in cycles (1..8); read issue to write-back.
N_PTS, 16, FFT size; fixed at 16, used for bound checks only.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  start request; accepted only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output beat
in_valid  in  1  input sample valid
in_ready  out  1  high in LOAD
ld_we  out  1  bank write for an input sample (in_valid & in_ready)
ld_addr  out  4  bank address for the current input sample
mux_sel  out  1  0 = bank write data from input, 1 = from butterfly
rd_en  out  1  bank 4-port read for butterfly issue
rd_addr  out  16  four 4-bit read addresses, leg k at [4k+3:4k]
tw_exp  out  12  twiddle exponents for legs 1..3, leg k at [4(k-1)+3:4(k-1)], mod 16
bf_valid  out  1  butterfly input valid (= rd_en)
stage  out  1  current compute stage
wr_en  out  1  butterfly write-back enable
wr_addr  out  16  four 4-bit write addresses, same packing as rd_addr
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_rd_addr  out  4  bank read address for the output beat
out_last  out  1  high on output beat 15

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation: immediate return to IDLE. Write pipeline cleared, so no late wr_en.
- States: IDLE, LOAD, S0_ISSUE, S0_DRAIN, S1_ISSUE, S1_DRAIN, UNLOAD.
- IDLE: start → LOAD, sample counter cleared. start while busy is ignored.
- LOAD:
  - in_ready=1, mux_sel=0.
  - Each handshake writes ld_addr = sample count (0..15) and increments the count.
  - After the 16th beat → S0_ISSUE.
- S0_ISSUE: one butterfly per cycle, b = 0..3, four cycles, stage=0, mux_sel=1.
  - rd_addr legs = b, b+4, b+8, b+12.
  - tw_exp leg k = (k·b) mod 16.
  - After b=3 → S0_DRAIN.
- S0_DRAIN: wait until the write pipeline is empty, i.e. BF_LAT cycles after the last issue → S1_ISSUE.
  - The bank is never read in the same cycle as a pending write to the same stage.
- S1_ISSUE: b = 0..3, stage=1.
  - rd_addr legs = 4b, 4b+1, 4b+2, 4b+3.
  - tw_exp all 0.
  - After b=3 → S1_DRAIN.
- S1_DRAIN: same drain rule → UNLOAD.
- Write-back:
  - Pipeline of depth BF_LAT carrying {valid, addr[15:0]}.
  - wr_en and wr_addr are the issue-cycle rd_en and rd_addr delayed exactly BF_LAT cycles (in-place).
- UNLOAD:
  - Output index n = 0..15.
  - out_rd_addr = digit-reverse(n) = {n[1:0], n[3:2]}.
  - out_valid=1; n advances only on out_valid & out_ready. out_valid holds while out_ready=0.
  - out_last = (n==15).
  - On the accepted last beat: done pulses in the next cycle and state → IDLE (busy low that cycle).
- Latency:
  - start → in_ready: 1 cycle.
  - Last load beat → first out_valid: 4 + BF_LAT + 4 + BF_LAT + 1 cycles.

Optional Feature:
FFT_R4_INVERSE_EN.
- Defined:
  - Adds input port inv (1 bit), sampled on start acceptance and held for the whole run.
  - When held high, each tw_exp leg = (16 − k·b) mod 16 in stage 0.
  - Output order is unchanged; scaling is the datapath's job.
- Undefined: no inv port, forward exponents only.

Decomposition:
- Package fft_r4_pkg:
  - State enum encoding.
  - Constants N_PTS=16, RADIX=4, N_STAGES=2, BF_PER_STAGE=4, ADDR_W=4.
  - Digit-reverse function.
  - Stage-0/stage-1 address-generation functions.
- Sub-module fft_r4_wb_delay: BF_LAT-deep valid+address shift pipeline with synchronous clear.

Test Plan:
- Reset during S0_ISSUE at b=2 with BF_LAT=2 → no wr_en afterwards; next start runs a full clean sequence.
- Full run, BF_LAT=2, out_ready=1:
  - ld_addr 0..15.
  - Stage-0 b=1 rd_addr=0xD951, tw_exp=0x321; b=3 tw_exp=0x963.
  - wr_en exactly 2 cycles after each rd_en.
  - Outputs on addr 0,4,8,12,1,5,…,15.
  - done exactly one cycle after the accepted last beat.
- Input stalls: in_valid toggles 1,0,1 → ld_addr advances only on handshakes; 16 writes total.
- Output backpressure: out_ready low for 3 cycles at n=5 → out_rd_addr holds 0x5, out_valid stays 1, no skip.
- start asserted in S1_ISSUE and in UNLOAD → ignored; sequence unchanged.
- FFT_R4_INVERSE_EN with inv=1 → stage-0 b=1 tw_exp=0xDEF; stage 1 all 0.
